// File: rtl/fu_result_queue_if.sv
// Result-bundle type and the FU-side/arbiter-side bus of the per-FU result queue.
// Signal suffixes are written from the queue's point of view.
package fu_result_queue_pkg;
    typedef struct packed {
        logic [15:0] opid;   // bit 15 is the lane-valid flag
        logic [31:0] data;
    } exe_bundle_t;
endpackage

interface fu_result_queue_if
    import fu_result_queue_pkg::*;
#(
    parameter int EWD   = 4,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                    flush_i;
    exe_bundle_t [EWD-1:0]   in_bundle_i;
    logic                    in_ready_o;
    exe_bundle_t [EWD-1:0]   resp_o;
    logic [EWD-1:0]          claim_i;
    logic [CW-1:0]           count_o;

    modport slave (
        input  flush_i, in_bundle_i, claim_i,
        output in_ready_o, resp_o, count_o
    );

    modport master (
        output flush_i, in_bundle_i, claim_i,
        input  in_ready_o, resp_o, count_o
    );
endinterface

// File: rtl/fu_result_queue.sv
// Age-ordered result buffer between one FU's writeback and the result arbiter.
// Oldest EWD entries are presented; claimed slots retire and survivors compact to index 0.
module fu_result_queue
    import fu_result_queue_pkg::*;
#(
    parameter int EWD   = 4,
    parameter int DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fu_result_queue_if.slave  fu
);
    localparam int CW = $clog2(DEPTH) + 1;

    exe_bundle_t     entry_q [DEPTH];
    exe_bundle_t     entry_d [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            in_ready;
    logic [DEPTH-1:0] drop;
    int              wr;

    // Deliberately ignores same-cycle claims so the producer never sees arbiter timing.
    assign in_ready = (count_q <= CW'(DEPTH - EWD));

    always_comb begin
        entry_d = '{default: '0};
        drop    = '0;
        drop[EWD-1:0] = fu.claim_i;
        wr      = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && !drop[i]) begin
                entry_d[wr] = entry_q[i];
                wr          = wr + 1;
            end
        end
        if (in_ready) begin
            for (int j = 0; j < EWD; j++) begin
                if (fu.in_bundle_i[j].opid[15] && (wr < DEPTH)) begin
                    entry_d[wr] = fu.in_bundle_i[j];
                    wr          = wr + 1;
                end
            end
        end
        if (fu.flush_i) begin
            entry_d = '{default: '0};
            wr      = 0;
        end
        count_d = CW'(wr);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '{default: '0};
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int j = 0; j < EWD; j++) begin
            fu.resp_o[j] = (CW'(j) < count_q) ? entry_q[j] : '0;
        end
    end

    assign fu.in_ready_o = in_ready;
    assign fu.count_o    = count_q;

endmodule

// File: tb/tb_fu_result_queue.sv
// Directed vector bench for fu_result_queue: per-cycle table plus hand-written
// full/drop and asynchronous-reset sequences.
module tb_fu_result_queue;
    import fu_result_queue_pkg::*;

    typedef exe_bundle_t [3:0] grp_t;

    typedef struct packed {
        logic             flush;
        logic [3:0]       claim;
        logic [3:0][15:0] in_op;    // [0] = lane 0; 0 means invalid lane
        logic [3:0]       exp_cnt;
        logic             exp_rdy;
        logic [3:0][15:0] exp_op;   // [0] = resp slot 0; 0 means empty slot
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   viol = 0;
    vec_t vecs [14];

    fu_result_queue_if #(.EWD(4), .DEPTH(8)) fu_if ();

    fu_result_queue #(.EWD(4), .DEPTH(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .fu     (fu_if)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a valid lane offered while the queue is not ready.
    always @(posedge clk) begin
        if (rst_n && !fu_if.in_ready_o && !fu_if.flush_i) begin
            for (int j = 0; j < 4; j++) begin
                if (fu_if.in_bundle_i[j].opid[15]) begin
                    viol = viol + 1;
                    break;
                end
            end
        end
    end

    function automatic exe_bundle_t mk_bundle(logic [15:0] op);
        exe_bundle_t b;
        b.opid = op;
        b.data = {16'hDA7A, op};
        return b;
    endfunction

    function automatic grp_t exp_grp(logic [3:0][15:0] ops);
        grp_t g;
        for (int j = 0; j < 4; j++) g[j] = (ops[j] == 16'h0) ? '0 : mk_bundle(ops[j]);
        return g;
    endfunction

    task automatic drive(logic fl, logic [3:0] cl, logic [3:0][15:0] ops);
        fu_if.flush_i = fl;
        fu_if.claim_i = cl;
        for (int j = 0; j < 4; j++) begin
            if (ops[j] == 16'h0) begin
                fu_if.in_bundle_i[j].opid = 16'h0123;
                fu_if.in_bundle_i[j].data = 32'hBAD0_0000 | 32'(j);
            end else begin
                fu_if.in_bundle_i[j] = mk_bundle(ops[j]);
            end
        end
    endtask

    task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(string nm, logic [3:0] cnt, logic rdy, logic [3:0][15:0] ops);
        chk({nm, " count"}, 192'(fu_if.count_o), 192'(cnt));
        chk({nm, " in_ready"}, 192'(fu_if.in_ready_o), 192'(rdy));
        chk({nm, " resp"}, 192'(fu_if.resp_o), 192'(exp_grp(ops)));
    endtask

    function automatic vec_t mk(logic fl, logic [3:0] cl, logic [3:0][15:0] in_op,
                                logic [3:0] cnt, logic rdy, logic [3:0][15:0] exp_op);
        vec_t v;
        v.flush = fl; v.claim = cl; v.in_op = in_op;
        v.exp_cnt = cnt; v.exp_rdy = rdy; v.exp_op = exp_op;
        return v;
    endfunction

    initial begin
        // Concatenations list lane/slot 3 first, lane/slot 0 last.
        vecs[0]  = mk(0, 4'b0000, {16'h8004, 16'h8003, 16'h8002, 16'h8001}, 4, 1, {16'h8004, 16'h8003, 16'h8002, 16'h8001});
        vecs[1]  = mk(0, 4'b0000, {16'h0000, 16'h8006, 16'h0000, 16'h8005}, 6, 0, {16'h8004, 16'h8003, 16'h8002, 16'h8001});
        vecs[2]  = mk(0, 4'b0101, 64'h0,                                     4, 1, {16'h8006, 16'h8005, 16'h8004, 16'h8002});
        vecs[3]  = mk(0, 4'b0000, {16'h800A, 16'h8009, 16'h8008, 16'h8007}, 8, 0, {16'h8006, 16'h8005, 16'h8004, 16'h8002});
        vecs[4]  = mk(0, 4'b1111, 64'h0,                                     4, 1, {16'h800A, 16'h8009, 16'h8008, 16'h8007});
        vecs[5]  = mk(0, 4'b0011, {16'h8011, 16'h0000, 16'h8010, 16'h0000}, 4, 1, {16'h8011, 16'h8010, 16'h800A, 16'h8009});
        vecs[6]  = mk(0, 4'b0100, 64'h0,                                     3, 1, {16'h0000, 16'h8011, 16'h800A, 16'h8009});
        vecs[7]  = mk(0, 4'b0011, {16'h8013, 16'h0000, 16'h8012, 16'h0000}, 3, 1, {16'h0000, 16'h8013, 16'h8012, 16'h8011});
        vecs[8]  = mk(0, 4'b1000, 64'h0,                                     3, 1, {16'h0000, 16'h8013, 16'h8012, 16'h8011});
        vecs[9]  = mk(0, 4'b0000, {16'h8023, 16'h8022, 16'h8021, 16'h8020}, 7, 0, {16'h8020, 16'h8013, 16'h8012, 16'h8011});
        vecs[10] = mk(0, 4'b0001, 64'h0,                                     6, 0, {16'h8021, 16'h8020, 16'h8013, 16'h8012});
        vecs[11] = mk(1, 4'b1111, {16'h8033, 16'h8032, 16'h8031, 16'h8030}, 0, 1, 64'h0);
        vecs[12] = mk(0, 4'b0000, {16'h0000, 16'h0000, 16'h0000, 16'h8030}, 1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h8030});
        vecs[13] = mk(0, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h8031}, 1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h8031});

        drive(0, 4'b0000, 64'h0);
        #1;
        chk_state("reset", 0, 1, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_state("post-reset idle", 0, 1, 64'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].flush, vecs[i].claim, vecs[i].in_op);
            @(negedge clk);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_rdy, vecs[i].exp_op);
        end

        // Full buffer: offered lanes are dropped, claims still retire.
        drive(1, 4'b0000, 64'h0);
        @(negedge clk);
        drive(0, 4'b0000, {16'h8043, 16'h8042, 16'h8041, 16'h8040});
        @(negedge clk);
        drive(0, 4'b0000, {16'h8047, 16'h8046, 16'h8045, 16'h8044});
        @(negedge clk);
        chk_state("full", 8, 0, {16'h8043, 16'h8042, 16'h8041, 16'h8040});
        drive(0, 4'b0000, {16'h8053, 16'h8052, 16'h8051, 16'h8050});
        @(negedge clk);
        chk_state("full drop", 8, 0, {16'h8043, 16'h8042, 16'h8041, 16'h8040});
        chk("violation seen", 192'(viol), 192'(1));
        drive(0, 4'b1111, 64'h0);
        @(negedge clk);
        chk_state("full claim", 4, 1, {16'h8047, 16'h8046, 16'h8045, 16'h8044});

        // Asynchronous reset mid-stream with five entries held.
        drive(0, 4'b0000, {16'h0000, 16'h0000, 16'h0000, 16'h8048});
        @(negedge clk);
        drive(0, 4'b0000, 64'h0);
        chk_state("pre-reset", 5, 0, {16'h8047, 16'h8046, 16'h8045, 16'h8044});
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async reset", 0, 1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_state("after reset", 0, 1, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
